// File: rtl/weight_row_sequencer_pkg.sv
// Shared definitions for the systolic-array weight-load path.
//
// Holds the sequencer state encoding and the default array geometry that the
// row sequencer, the one-hot row decoder and the PE array all agree on.
package weight_row_sequencer_pkg;

    // Default array geometry shared with the decoder and PE array
    localparam int WRS_ROWS   = 8;
    localparam int WRS_COLS   = 8;
    localparam int WRS_DATA_W = 8;

    // Width of one packed weight row at the default geometry
    localparam int ROW_W = WRS_COLS * WRS_DATA_W;

    // Sequencer states, fixed 2-bit encoding so existing netlists can decode them
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } wrs_state_e;

endpackage

// File: rtl/weight_row_sequencer.sv
// Weight row sequencer.
//
// Accepts a burst of ROWS weight rows over a valid/ready stream, one row per
// beat, and replays each accepted row one cycle later as row_data together
// with its binary row index and a write strobe. The parent feeds row_idx into
// the one-hot row decoder and ANDs the decoder output with row_we, so exactly
// one PE row latches weights per accepted beat.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     one-cycle request to begin a ROWS-row load (honoured in IDLE only)
//   abort     synchronous cancel of an in-progress load
//   in_valid  upstream row beat valid
//   in_ready  sequencer can accept a beat (LOAD and no abort)
//   in_data   packed weight row, PE0 in the LSBs
//   row_idx   target row index for the decoder
//   row_we    write strobe qualifying the decoder output
//   row_data  registered copy of the accepted row
//   busy      high while loading
//   done      one-cycle pulse coincident with the final row write
module weight_row_sequencer
    import weight_row_sequencer_pkg::*;
#(
    parameter int ROWS   = WRS_ROWS,
    parameter int COLS   = WRS_COLS,
    parameter int DATA_W = WRS_DATA_W,
    parameter int IDX_W  = $clog2(ROWS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [COLS*DATA_W-1:0]   in_data,
    output logic [IDX_W-1:0]         row_idx,
    output logic                     row_we,
    output logic [COLS*DATA_W-1:0]   row_data,
    output logic                     busy,
    output logic                     done
);

    // Index of the final row; the counter stops here, so row_idx never
    // reaches an unused decoder output when ROWS is not a power of two.
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

    wrs_state_e       state;
    logic [IDX_W-1:0] cnt;
    logic             accept;

    // Handshake and status decode straight from the state register. abort
    // kills in_ready in the same cycle so the aborted beat is never taken.
    assign in_ready = (state == LOAD) && !abort;
    assign busy     = (state == LOAD);
    assign done     = (state == DONE);
    assign accept   = in_valid && in_ready;

    // Sequencer FSM, row counter and output registers. row_we is a one-cycle
    // strobe: it defaults low and is only raised on the edge that accepts a
    // beat, while row_idx/row_data hold their last values between accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            row_idx  <= '0;
            row_we   <= 1'b0;
            row_data <= '0;
        end else begin
            row_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (accept) begin
                        row_data <= in_data;
                        row_idx  <= cnt;
                        row_we   <= 1'b1;
                        if (cnt == LAST_ROW) begin
                            state <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_row_sequencer.sv
// Self-checking bench for weight_row_sequencer.
//
// Two instances share the same stimulus: an 8-row array and a 6-row array
// (non-power-of-two, 3-bit index). A row-level reference model predicts the
// handshake and the writes each instance must make; predicted writes go into
// a per-instance scoreboard queue and a separate monitor compares them with
// whatever the instances present after every rising edge.
module tb_weight_row_sequencer;

    localparam int COLS   = 8;
    localparam int DATA_W = 8;
    localparam int RW     = COLS * DATA_W;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          in_valid;
    logic [RW-1:0] in_data;

    logic          in_ready0, row_we0, busy0, done0;
    logic [2:0]    row_idx0;
    logic [RW-1:0] row_data0;
    logic          in_ready1, row_we1, busy1, done1;
    logic [2:0]    row_idx1;
    logic [RW-1:0] row_data1;

    // One predicted row write: the cycle it must appear in, its row, its data,
    // and whether it is the final row (done must accompany it)
    typedef struct {
        int            cyc;
        int            idx;
        logic [RW-1:0] data;
        bit            last;
    } exp_t;

    exp_t sb_q[2][$];

    // Reference model state per instance: rows loaded so far in this burst
    int model_rows[2] = '{8, 6};
    bit model_active[2];
    bit model_in_done[2];
    int model_loaded[2];

    int checks;
    int failures;
    int cycle_count;

    weight_row_sequencer #(.ROWS(8), .COLS(COLS), .DATA_W(DATA_W)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .row_idx(row_idx0), .row_we(row_we0), .row_data(row_data0),
        .busy(busy0), .done(done0)
    );

    weight_row_sequencer #(.ROWS(6), .COLS(COLS), .DATA_W(DATA_W)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .row_idx(row_idx1), .row_we(row_we1), .row_data(row_data1),
        .busy(busy1), .done(done1)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle number used to time-stamp predicted writes
    initial cycle_count = 0;
    always @(posedge clk) cycle_count++;

    task automatic compareValue(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle_count);
        end
    endtask

    // Monitor comparison for one instance after a rising edge
    task automatic checkOutput(input int inst, input logic we, input logic [2:0] idx,
                               input logic [RW-1:0] data, input logic dn, input int now);
        exp_t e;
        string tag;
        tag = (inst == 0) ? "rows8" : "rows6";
        if (sb_q[inst].size() > 0 && sb_q[inst][0].cyc == now) begin
            e = sb_q[inst].pop_front();
            compareValue({tag, " row_we"}, RW'(we), RW'(1));
            if (we) begin
                compareValue({tag, " row_idx"}, RW'(idx), RW'(e.idx));
                compareValue({tag, " row_data"}, data, e.data);
            end
            compareValue({tag, " done"}, RW'(dn), RW'(e.last));
        end else begin
            compareValue({tag, " spurious row_we"}, RW'(we), RW'(0));
            compareValue({tag, " spurious done"}, RW'(dn), RW'(0));
        end
    endtask

    // Monitor: decoupled from stimulus, samples 1 ns after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                checkOutput(0, row_we0, row_idx0, row_data0, done0, cycle_count);
                checkOutput(1, row_we1, row_idx1, row_data1, done1, cycle_count);
            end
        end
    end

    task automatic checkResetState();
        compareValue("rows8 reset row_we", RW'(row_we0), '0);
        compareValue("rows8 reset row_idx", RW'(row_idx0), '0);
        compareValue("rows8 reset row_data", row_data0, '0);
        compareValue("rows8 reset done", RW'(done0), '0);
        compareValue("rows8 reset busy", RW'(busy0), '0);
        compareValue("rows8 reset in_ready", RW'(in_ready0), '0);
        compareValue("rows6 reset row_we", RW'(row_we1), '0);
        compareValue("rows6 reset row_idx", RW'(row_idx1), '0);
        compareValue("rows6 reset row_data", row_data1, '0);
        compareValue("rows6 reset done", RW'(done1), '0);
        compareValue("rows6 reset busy", RW'(busy1), '0);
        compareValue("rows6 reset in_ready", RW'(in_ready1), '0);
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            model_active[i]  = 1'b0;
            model_in_done[i] = 1'b0;
            model_loaded[i]  = 0;
            sb_q[i].delete();
        end
    endtask

    // One cycle of the row-level model for instance i, given the inputs
    // presented before the next rising edge
    task automatic modelStep(input int i, input logic s, input logic a, input logic v, input logic [RW-1:0] d);
        exp_t e;
        if (model_in_done[i]) begin
            model_in_done[i] = 1'b0;
        end else if (!model_active[i]) begin
            if (s) begin
                model_active[i] = 1'b1;
                model_loaded[i] = 0;
            end
        end else if (a) begin
            model_active[i] = 1'b0;
            model_loaded[i] = 0;
        end else if (v) begin
            e.cyc  = cycle_count + 1;
            e.idx  = model_loaded[i];
            e.data = d;
            e.last = (model_loaded[i] == model_rows[i] - 1);
            sb_q[i].push_back(e);
            model_loaded[i]++;
            if (e.last) begin
                model_active[i]  = 1'b0;
                model_in_done[i] = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs on the falling edge, check the combinational
    // handshake against the model, then advance the model
    task automatic applyStimulus(input logic s, input logic a, input logic v, input logic [RW-1:0] d);
        @(negedge clk);
        start    = s;
        abort    = a;
        in_valid = v;
        in_data  = d;
        #1;
        compareValue("rows8 in_ready", RW'(in_ready0), RW'(model_active[0] && !a));
        compareValue("rows8 busy", RW'(busy0), RW'(model_active[0]));
        compareValue("rows6 in_ready", RW'(in_ready1), RW'(model_active[1] && !a));
        compareValue("rows6 busy", RW'(busy1), RW'(model_active[1]));
        modelStep(0, s, a, v, d);
        modelStep(1, s, a, v, d);
    endtask

    function automatic logic [RW-1:0] randRow();
        return {$urandom(), $urandom()};
    endfunction

    // Main stimulus sequence
    initial begin
        logic [7:0] b;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        modelReset();
        #1;
        checkResetState();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic load: rows 0x11..0x88 replicated across the PEs, back to back
        $display("[TB] basic load");
        applyStimulus(1, 0, 0, '0);
        for (int k = 0; k < 8; k++) begin
            b = 8'((k + 1) * 8'h11);
            applyStimulus(0, 0, 1, {8{b}});
        end
        repeat (3) applyStimulus(0, 0, 0, '0);

        // Gapped stream: valid on every third cycle
        $display("[TB] gapped stream");
        applyStimulus(1, 0, 0, '0);
        for (int k = 0; k < 24; k++) applyStimulus(0, 0, (k % 3) == 0, randRow());
        repeat (3) applyStimulus(0, 0, 0, '0);

        // Abort after three accepts, stray beats while idle, then a clean restart
        $display("[TB] abort");
        applyStimulus(1, 0, 0, '0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, randRow());
        applyStimulus(0, 1, 1, randRow());
        repeat (2) applyStimulus(0, 0, 1, randRow());
        applyStimulus(1, 1, 0, '0);
        for (int k = 0; k < 8; k++) applyStimulus(0, 0, 1, randRow());
        repeat (3) applyStimulus(0, 0, 0, '0);

        // start re-pulsed mid-load and during the 8-row DONE cycle
        $display("[TB] start while busy");
        applyStimulus(1, 0, 0, '0);
        for (int k = 0; k < 10; k++) applyStimulus(k == 3 || k == 8, 0, 1, randRow());
        applyStimulus(0, 1, 0, '0);
        repeat (2) applyStimulus(0, 0, 0, '0);

        // Randomized mix of start, abort and valid
        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(9) == 0, $urandom_range(19) == 0,
                          $urandom_range(1) == 1, randRow());
        end
        applyStimulus(0, 1, 0, '0);
        applyStimulus(0, 1, 0, '0);
        repeat (2) applyStimulus(0, 0, 0, '0);

        // Asynchronous reset after five accepts
        $display("[TB] async reset mid-load");
        applyStimulus(1, 0, 0, '0);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 1, randRow());
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        #1;
        checkResetState();
        modelReset();
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (4) applyStimulus(0, 0, 1, randRow());

        // Every predicted write must have been seen
        repeat (2) applyStimulus(0, 0, 0, '0);
        compareValue("rows8 pending writes", RW'(sb_q[0].size()), '0);
        compareValue("rows6 pending writes", RW'(sb_q[1].size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
